// File: rtl/prg_ray_queue_pkg.sv
// Shared ray-tracer types and constants for the primary-ray queue.
//   float_t  - raw IEEE-754 single-precision bit pattern
//   vector_t - three float_t components
//   ray_t    - origin, direction and a frame-local ray identifier
//   state_t  - frame-tracking states of the queue controller
package prg_ray_queue_pkg;

    typedef logic [31:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vector_t;

    localparam int unsigned RAY_ID_W         = 19;
    localparam int unsigned RX_W             = 19;
    localparam int unsigned NUM_RAYS_DEFAULT = 307200;

    typedef struct packed {
        vector_t               origin;
        vector_t               direction;
        logic [RAY_ID_W-1:0]   rayID;
    } ray_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    // Saturating accepted-push counter step.
    function automatic logic [RX_W-1:0] rx_step(input logic [RX_W-1:0] cur,
                                                input logic            inc,
                                                input logic [RX_W-1:0] limit);
        return (inc && (cur < limit)) ? cur + 1'b1 : cur;
    endfunction

endpackage

// File: rtl/prg_ray_queue_if.sv
// Ray stream bundle between the primary ray generator, the queue and the
// downstream consumer.
//   rayReady  - single-cycle push strobe, prg_data valid with it
//   prg_data  - ray to push
//   prg_done  - generator end-of-frame pulse
//   out_valid - out_ray holds the head-of-queue ray
//   out_ray   - head-of-queue ray
//   out_ready - consumer accepts the head ray
// slave: queue side; master: generator/consumer side.
interface prg_ray_queue_if;
    import prg_ray_queue_pkg::*;

    logic rayReady;
    ray_t prg_data;
    logic prg_done;
    logic out_valid;
    ray_t out_ray;
    logic out_ready;

    modport slave (
        input  rayReady,
        input  prg_data,
        input  prg_done,
        input  out_ready,
        output out_valid,
        output out_ray
    );

    modport master (
        output rayReady,
        output prg_data,
        output prg_done,
        output out_ready,
        input  out_valid,
        input  out_ray
    );

endinterface

// File: rtl/prg_ray_queue_fifo.sv
// prq_fifo: ray storage with wrapping read/write pointers and occupancy.
//   clk, rst - clock, asynchronous active-high reset (pointers/count only)
//   push     - write wdata (caller guarantees !full or a same-cycle pop)
//   pop      - advance the read pointer (caller guarantees !empty)
//   rdata    - head entry, read straight from registered storage
//   empty, full, count - occupancy status
module prq_fifo
    import prg_ray_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  ray_t                     wdata,
    output ray_t                     rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    ray_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/prg_ray_queue.sv
// prg_ray_queue: elastic buffer between the primary ray generator and the
// traversal pipeline, with per-frame tracking.
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - prg_ray_queue_if.slave ray stream (push side and pop side)
//   almost_full - occupancy >= DEPTH-2
//   frame_done  - one-cycle pulse when a finished frame has fully drained
//   overflow    - sticky, a ray was dropped on a full queue (cleared at frame start)
//   occupancy   - current entry count
//   seq_err     - only with PRG_RAY_QUEUE_SEQ_CHECK_EN: sticky rayID sequence error
module prg_ray_queue
    import prg_ray_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NUM_RAYS = NUM_RAYS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    prg_ray_queue_if.slave           bus,
    output logic                     almost_full,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
    ,
    output logic                     seq_err
`endif
);

    localparam int unsigned     OCC_W = $clog2(DEPTH) + 1;
    localparam logic [RX_W-1:0] LIMIT = RX_W'(NUM_RAYS);

    state_t           state;
    state_t           state_next;
    logic [RX_W-1:0]  rx_count;
    logic [RX_W-1:0]  rx_next;
    logic             frame_done_next;
    logic             overflow_next;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [OCC_W-1:0] occ_next;
    ray_t             head;

    assign pop      = bus.out_valid & bus.out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok  = bus.rayReady & (~full | pop);
    assign occ_next = occupancy + OCC_W'(push_ok) - OCC_W'(pop);

    prq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata (bus.prg_data),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (occupancy)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_ray   = head;
    assign almost_full   = (occupancy >= OCC_W'(DEPTH - 2));

    always_comb begin
        state_next      = state;
        rx_next         = rx_count;
        frame_done_next = 1'b0;
        overflow_next   = overflow | (bus.rayReady & ~push_ok);
        case (state)
            IDLE: begin
                if (bus.rayReady) begin
                    state_next    = FILL;
                    rx_next       = RX_W'(1);
                    overflow_next = 1'b0;
                end
            end
            FILL: begin
                rx_next = rx_step(rx_count, push_ok, LIMIT);
                // End of frame that also drains the queue skips DRAIN.
                if ((rx_next == LIMIT) || bus.prg_done) begin
                    if (occ_next == '0) begin
                        state_next      = IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                rx_next = rx_step(rx_count, push_ok, LIMIT);
                if (occ_next == '0) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_count   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            rx_count   <= rx_next;
            frame_done <= frame_done_next;
            overflow   <= overflow_next;
        end
    end

`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
    logic [RAY_ID_W-1:0] expected_id;
    logic [RAY_ID_W-1:0] expected_now;

    // The push that starts a frame is checked against 0.
    assign expected_now = (state == IDLE) ? '0 : expected_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected_id <= '0;
            seq_err     <= 1'b0;
        end else if (push_ok) begin
            expected_id <= bus.prg_data.rayID + 1'b1;
            if (bus.prg_data.rayID != expected_now) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    // Sequence checker not built.
`endif

endmodule

// File: tb/tb_prg_ray_queue.sv
// Testbench for prg_ray_queue (DEPTH=8, NUM_RAYS=16). A queue-based reference
// model is compared with the DUT on every falling edge; directed scenarios add
// literal expectations. PRG_RAY_QUEUE_SEQ_CHECK_EN enables the seq_err checks.
module tb_prg_ray_queue;
    import prg_ray_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int NR    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prg_ray_queue_if bus ();
    logic       almost_full;
    logic       frame_done;
    logic       overflow;
    logic [3:0] occupancy;
`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
    logic       seq_err;
`endif

    prg_ray_queue #(
        .DEPTH    (DEPTH),
        .NUM_RAYS (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .almost_full (almost_full),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .occupancy   (occupancy)
`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
        ,
        .seq_err     (seq_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ray_t mk(input int id);
        ray_t r;
        r.origin.x    = 32'(id * 7 + 1);
        r.origin.y    = 32'h3f80_0000 ^ 32'(id);
        r.origin.z    = 32'(id << 4);
        r.direction.x = ~32'(id);
        r.direction.y = 32'(id * id);
        r.direction.z = 32'h4000_0000 + 32'(id);
        r.rayID       = RAY_ID_W'(id);
        return r;
    endfunction

    // Reference model
    ray_t   mq[$];
    state_t ms   = IDLE;
    int     mrx  = 0;
    logic   movf = 1'b0;
    logic   mfd  = 1'b0;
    int     mexp = 0;
    logic   mseq = 1'b0;

    always @(negedge clk) begin : model
        bit   pop;
        bit   acc;
        int   occ_after;
        ray_t d;
        if (rst) begin
            mq.delete();
            ms = IDLE; mrx = 0; movf = 1'b0; mfd = 1'b0; mexp = 0; mseq = 1'b0;
        end
        chk("m_out_valid", bus.out_valid, mq.size() != 0);
        if (mq.size() != 0) chk("m_out_ray", bus.out_ray, mq[0]);
        chk("m_occupancy", occupancy, mq.size());
        chk("m_almost_full", almost_full, mq.size() >= DEPTH - 2);
        chk("m_overflow", overflow, movf);
        chk("m_frame_done", frame_done, mfd);
        chk("m_state", dut.state, ms);
        chk("m_rx_count", dut.rx_count, mrx);
`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
        chk("m_seq_err", seq_err, mseq);
`endif
        if (!rst) begin
            pop       = (mq.size() != 0) && bus.out_ready;
            acc       = bus.rayReady && ((mq.size() < DEPTH) || pop);
            d         = bus.prg_data;
            occ_after = mq.size() + int'(acc) - int'(pop);
            mfd       = 1'b0;
            if (acc) begin
                if (int'(d.rayID) != ((ms == IDLE) ? 0 : mexp)) mseq = 1'b1;
                mexp = int'(d.rayID) + 1;
            end
            if (bus.rayReady && !acc) movf = 1'b1;
            case (ms)
                IDLE: if (bus.rayReady) begin ms = FILL; mrx = 1; movf = 1'b0; end
                FILL: begin
                    if (acc && mrx < NR) mrx++;
                    if (mrx == NR || bus.prg_done) begin
                        if (occ_after == 0) begin ms = IDLE; mfd = 1'b1; end
                        else ms = DRAIN;
                    end
                end
                default: begin
                    if (acc && mrx < NR) mrx++;
                    if (occ_after == 0) begin ms = IDLE; mfd = 1'b1; end
                end
            endcase
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    end

    // One cycle of stimulus; returns 1 time unit after the active edge.
    task automatic cyc(input logic rr, input int id, input logic ordy, input logic done);
        bus.rayReady  = rr;
        bus.prg_data  = mk(id);
        bus.out_ready = ordy;
        bus.prg_done  = done;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int pulses;
        rst           = 1'b1;
        bus.rayReady  = 1'b0;
        bus.prg_data  = mk(0);
        bus.prg_done  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_state", dut.state, IDLE);
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        // Single ray in, out next cycle, popped
        cyc(1, 0, 1, 0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_id", bus.out_ray.rayID, 0);
        chk("t1_occ", occupancy, 1);
        cyc(0, 0, 1, 0);
        chk("t1_occ0", occupancy, 0);
        cyc(0, 0, 1, 1);
        chk("t1_frame_done", frame_done, 1);
        chk("t1_state", dut.state, IDLE);
        cyc(0, 0, 0, 0);

        // Nine pushes into DEPTH=8 with no consumer
        for (int i = 0; i < 9; i++) begin
            cyc(1, i, 0, 0);
            chk("t2_occ", occupancy, (i < 8) ? i + 1 : 8);
            chk("t2_af", almost_full, ((i < 8) ? i + 1 : 8) >= 6);
        end
        chk("t2_overflow", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", bus.out_ray.rayID, i);
            cyc(0, 0, 1, 0);
        end
        chk("t2_ninth_absent", bus.out_valid, 0);
        cyc(0, 0, 0, 1);

        // Full queue, push and pop together
        for (int i = 0; i < 8; i++) cyc(1, i, 0, 0);
        chk("t3_full", occupancy, 8);
        cyc(1, 8, 1, 0);
        chk("t3_occ", occupancy, 8);
        chk("t3_no_ovf", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_order", bus.out_ray.rayID, i);
            cyc(0, 0, 1, 0);
        end
        chk("t3_empty", bus.out_valid, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // Pushes accepted during DRAIN
        for (int i = 0; i < 3; i++) cyc(1, i, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t5_drain", dut.state, DRAIN);
        cyc(1, 3, 0, 0);
        cyc(1, 4, 0, 0);
        chk("t5_occ", occupancy, 5);
        chk("t5_rx", dut.rx_count, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t5_order", bus.out_ray.rayID, i);
            cyc(0, 0, 1, 0);
        end
        chk("t5_fd", frame_done, 1);
        chk("t5_idle", dut.state, IDLE);
        cyc(0, 0, 0, 0);

        // Full NUM_RAYS frame, one push every third cycle
        pulses = 0;
        for (int i = 0; i < NR; i++) begin
            cyc(1, i, 1, 0);
            pulses += int'(frame_done);
            if (i == NR - 1) begin
                chk("t4_drain", dut.state, DRAIN);
                chk("t4_rx", dut.rx_count, NR);
            end
            cyc(0, 0, 1, 0);
            pulses += int'(frame_done);
            cyc(0, 0, 1, 0);
            pulses += int'(frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            pulses += int'(frame_done);
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_idle", dut.state, IDLE);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) cyc(1, i, 0, 0);
        chk("t6_occ5", occupancy, 5);
        bus.rayReady = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_state", dut.state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("t6_new_valid", bus.out_valid, 1);
        chk("t6_new_id", bus.out_ray.rayID, 0);
        chk("t6_new_occ", occupancy, 1);
        chk("t6_new_rx", dut.rx_count, 1);
        cyc(0, 0, 1, 1);

`ifdef PRG_RAY_QUEUE_SEQ_CHECK_EN
        // rayID sequence 0,1,3
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        chk("t7_seq_ok", seq_err, 0);
        cyc(1, 3, 1, 0);
        chk("t7_seq_err", seq_err, 1);
        cyc(0, 0, 1, 1);
`endif

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
